cam_pwr_seq: RTL
================

// Module: cam_pwr_seq
// PURPOSE
//  Parametrised power-up, reset and standby sequencer for 1..NUM_CAM OV5640-class sensors.
//  Drives per-camera PWDN and RESET_N lines and releases the cameras one at a time, which limits inrush current.
//  Asserts power_done once every camera has settled; power_done gates the SCCB/I2C controller reset.
//  Adds runtime standby/wake and a soft restart on top of the fixed single-camera timer chain.
// PARAMETERS
//  NUM_CAM      2           number of cameras, 1..4
//  CLK_FREQ_HZ  50_000_000  sys_clk frequency; ticks per us = CLK_FREQ_HZ/1_000_000 (must be an exact integer)
//  T_PWDN_US    6000        PWDN hold time after reset, all cameras
//  T_RST_US     2000        RESET_N low time after a camera's PWDN release
//  T_SETTLE_US  21000       settle time after RESET_N release, and after wake
//  T_CFG_TO_US  100000      cfg_done timeout (watchdog only)
//  MAX_RETRY    3           restart attempts before fault (watchdog only)
//  CNT_W        32          timer width; an elaboration check fails if CNT_W cannot hold the largest tick count
// PORTS
//  sys_clk       in   1        single clock
//  sys_rst       in   1        asynchronous, active-high reset
//  restart       in   1        1-cycle pulse: rerun the full sequence from PWDN
//  standby_req   in   1        level: 1 = enter standby, 0 = wake
//  cfg_done      in   1        register configuration complete (used by the watchdog)
//  cam_pwdn      out  NUM_CAM  per-camera power-down, 1 = powered down
//  cam_rst_n     out  NUM_CAM  per-camera reset, active low
//  power_done    out  1        all cameras powered and settled
//  seq_busy      out  1        1 while a sequence or wake is in progress
//  cur_cam       out  2        index of the camera currently sequencing
//  pwr_fault     out  1        watchdog retries exhausted
// BEHAVIOUR
//  Reset values: cam_pwdn all 1; cam_rst_n all 0; power_done 0; seq_busy 1; cur_cam 0; pwr_fault 0.
//  After reset the FSM is in S_PWDN with timer = 0.
//  Timer: cleared on every state entry; increments each cycle; leaves the state after exactly N ticks (terminal count N-1).
//  All outputs are registered and decoded from the state and camera index.
//  FSM states and transitions:
//   S_PWDN   all pwdn=1, rst_n=0; after T_PWDN -> S_RST, cur_cam=0.
//   S_RST    cam_pwdn[cur_cam]=0; after T_RST -> S_SETTLE.
//   S_SETTLE cam_rst_n[cur_cam]=1; after T_SETTLE:
//            if cur_cam==NUM_CAM-1 -> S_DONE; else cur_cam+1 -> S_RST.
//   S_DONE   power_done=1, seq_busy=0; standby_req=1 -> S_STBY.
//   S_STBY   all pwdn=1, rst_n unchanged (1), power_done=0, seq_busy=0; standby_req=0 -> S_WAKE.
//   S_WAKE   all pwdn=0, seq_busy=1; after T_SETTLE -> S_DONE.
//   S_FAULT  all pwdn=1, rst_n=0, pwr_fault=1; leaves only on restart or sys_rst.
//  Cameras already released stay released while later cameras sequence.
//  restart in any state: next cycle is S_PWDN with timer=0 and all outputs at reset values.
//   restart clears the retry count and pwr_fault.
//  Priority when events coincide: sys_rst > restart > timer expiry > standby_req.
//  standby_req is sampled only in S_DONE and S_STBY. A level held during sequencing takes effect on reaching S_DONE.
//  sys_rst asserted mid-sequence: all outputs return to reset values asynchronously.
// CONFIGURATION
//  CAM_PWR_WDOG_EN defined:
//   In S_DONE the timer counts until cfg_done=1.
//   If T_CFG_TO elapses first: retry_cnt+1; if retry_cnt<MAX_RETRY -> S_PWDN, else -> S_FAULT.
//   cfg_done=1 stops the timer; retry_cnt is held.
//   Wake (S_WAKE -> S_DONE) does not rearm the watchdog.
//  CAM_PWR_WDOG_EN undefined:
//   cfg_done is ignored; pwr_fault is tied 0; S_FAULT is unreachable; no retry logic.
//   Port list is identical in both builds.
// TESTING  (CLK_FREQ_HZ=1_000_000, NUM_CAM=2, T_PWDN=6, T_RST=2, T_SETTLE=21; cycle n = nth edge after sys_rst falls)
//  1 Power-up -> pwdn[0] falls @6, rst_n[0] rises @8, pwdn[1] falls @29, rst_n[1] rises @31, power_done rises @52.
//  2 NUM_CAM=1 -> power_done @29; check reset values of all outputs before cycle 1.
//  3 standby_req=1 @60 -> pwdn=2'b11, power_done=0 @61; standby_req=0 @70 -> pwdn=2'b00 @71, power_done @92.
//  4 restart @20 (cam0 settling) -> @21 pwdn=2'b11, rst_n=2'b00, cur_cam=0; sequence repeats with all times +21.
//  5 restart and standby_req both asserted @60 in S_DONE -> restart wins: S_PWDN, power_done=0.
//  6 WDOG_EN, T_CFG_TO=10, MAX_RETRY=2, cfg_done held 0 -> two full re-sequences, then pwr_fault=1 and pwdn=2'b11.
//     A following restart clears pwr_fault.

Source files
------------

// File: rtl/cam_pwr_seq.sv
// Power-up, reset and standby sequencer for 1..NUM_CAM OV5640-class sensors.
// Optional cfg_done watchdog with retries is built when CAM_PWR_WDOG_EN is defined.
module cam_pwr_seq #(
    parameter int unsigned NUM_CAM     = 2,
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned T_PWDN_US   = 6000,
    parameter int unsigned T_RST_US    = 2000,
    parameter int unsigned T_SETTLE_US = 21000,
    parameter int unsigned T_CFG_TO_US = 100000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned CNT_W       = 32
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               restart,
    input  logic               standby_req,
    input  logic               cfg_done,
    output logic [NUM_CAM-1:0] cam_pwdn,
    output logic [NUM_CAM-1:0] cam_rst_n,
    output logic               power_done,
    output logic               seq_busy,
    output logic [1:0]         cur_cam,
    output logic               pwr_fault
);

    localparam longint unsigned TICKS_US = 64'(CLK_FREQ_HZ) / 64'd1_000_000;
    localparam longint unsigned N_PWDN   = 64'(T_PWDN_US) * TICKS_US;
    localparam longint unsigned N_RST    = 64'(T_RST_US) * TICKS_US;
    localparam longint unsigned N_SETTLE = 64'(T_SETTLE_US) * TICKS_US;
    localparam longint unsigned N_SEQMAX = (N_PWDN > N_RST) ?
        ((N_PWDN > N_SETTLE) ? N_PWDN : N_SETTLE) :
        ((N_RST > N_SETTLE) ? N_RST : N_SETTLE);
`ifdef CAM_PWR_WDOG_EN
    localparam longint unsigned N_CFG_TO = 64'(T_CFG_TO_US) * TICKS_US;
    localparam longint unsigned N_MAX    = (N_CFG_TO > N_SEQMAX) ? N_CFG_TO : N_SEQMAX;
    localparam logic [CNT_W-1:0] TC_CFG  = CNT_W'(N_CFG_TO - 64'd1);
`else
    localparam longint unsigned N_MAX    = N_SEQMAX;
`endif

    localparam logic [CNT_W-1:0] TC_PWDN   = CNT_W'(N_PWDN - 64'd1);
    localparam logic [CNT_W-1:0] TC_RST    = CNT_W'(N_RST - 64'd1);
    localparam logic [CNT_W-1:0] TC_SETTLE = CNT_W'(N_SETTLE - 64'd1);
    localparam logic [1:0]       LAST_CAM  = 2'(NUM_CAM - 1);

    if (CLK_FREQ_HZ % 1_000_000 != 0) begin : g_chk_freq
        $error("CLK_FREQ_HZ must be a whole number of MHz");
    end
    if (NUM_CAM < 1 || NUM_CAM > 4) begin : g_chk_cams
        $error("NUM_CAM must be 1..4");
    end
    if (N_PWDN == 0 || N_RST == 0 || N_SETTLE == 0 || T_CFG_TO_US == 0) begin : g_chk_zero
        $error("all sequence times must be at least one tick");
    end
    if (CNT_W < 64 && (N_MAX - 64'd1) >= (64'd1 << CNT_W)) begin : g_chk_cnt
        $error("CNT_W too narrow for the largest tick count");
    end
    if (MAX_RETRY > 254) begin : g_chk_retry
        $error("MAX_RETRY must fit the 8-bit retry counter");
    end

    typedef enum logic [2:0] {
        S_PWDN, S_RST, S_SETTLE, S_DONE, S_STBY, S_WAKE, S_FAULT
    } state_t;

    state_t             r_state, w_state_d;
    logic [1:0]         r_cam, w_cam_d;
    logic [CNT_W-1:0]   r_timer, w_timer_d;
    logic [NUM_CAM-1:0] r_pwdn, r_rst_n, w_pwdn_d, w_rst_n_d;
    logic               r_done, r_busy, r_fault, w_done_d, w_busy_d, w_fault_d;
`ifdef CAM_PWR_WDOG_EN
    logic [7:0]         r_retry, w_retry_d;
    logic               r_wdog_arm, w_wdog_arm_d;
`else
    logic               w_unused_cfg;
    assign w_unused_cfg = cfg_done;
`endif

    always_comb begin
        w_state_d = r_state;
        w_cam_d   = r_cam;
        w_timer_d = r_timer + CNT_W'(1);
`ifdef CAM_PWR_WDOG_EN
        w_retry_d    = r_retry;
        w_wdog_arm_d = r_wdog_arm;
`endif
        if (restart) begin
            w_state_d = S_PWDN;
            w_cam_d   = 2'd0;
            w_timer_d = '0;
`ifdef CAM_PWR_WDOG_EN
            w_retry_d    = 8'd0;
            w_wdog_arm_d = 1'b0;
`endif
        end else begin
            case (r_state)
                S_PWDN: if (r_timer == TC_PWDN) begin
                    w_state_d = S_RST;
                    w_cam_d   = 2'd0;
                    w_timer_d = '0;
                end
                S_RST: if (r_timer == TC_RST) begin
                    w_state_d = S_SETTLE;
                    w_timer_d = '0;
                end
                S_SETTLE: if (r_timer == TC_SETTLE) begin
                    w_timer_d = '0;
                    if (r_cam == LAST_CAM) begin
                        w_state_d = S_DONE;
`ifdef CAM_PWR_WDOG_EN
                        w_wdog_arm_d = 1'b1;
`endif
                    end else begin
                        w_state_d = S_RST;
                        w_cam_d   = r_cam + 2'd1;
                    end
                end
                S_DONE: begin
`ifdef CAM_PWR_WDOG_EN
                    // Watchdog runs only after a full sequence, until cfg_done is first seen.
                    if (r_wdog_arm && cfg_done) begin
                        w_wdog_arm_d = 1'b0;
                        w_timer_d    = r_timer;
                    end else if (r_wdog_arm && r_timer == TC_CFG) begin
                        w_wdog_arm_d = 1'b0;
                        w_retry_d    = r_retry + 8'd1;
                        w_timer_d    = '0;
                        w_cam_d      = 2'd0;
                        w_state_d    = (r_retry < 8'(MAX_RETRY)) ? S_PWDN : S_FAULT;
                    end else if (standby_req) begin
                        w_state_d = S_STBY;
                        w_timer_d = '0;
                    end else if (!r_wdog_arm) begin
                        w_timer_d = r_timer;
                    end
`else
                    w_timer_d = r_timer;
                    if (standby_req) begin
                        w_state_d = S_STBY;
                        w_timer_d = '0;
                    end
`endif
                end
                S_STBY: begin
                    w_timer_d = r_timer;
                    if (!standby_req) begin
                        w_state_d = S_WAKE;
                        w_timer_d = '0;
                    end
                end
                S_WAKE: if (r_timer == TC_SETTLE) begin
                    w_state_d = S_DONE;
                    w_timer_d = '0;
                end
                S_FAULT: w_timer_d = r_timer;
                default: begin
                    w_state_d = S_PWDN;
                    w_cam_d   = 2'd0;
                    w_timer_d = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so outputs change on the transition edge.
    always_comb begin
        w_pwdn_d  = '1;
        w_rst_n_d = '0;
        w_done_d  = 1'b0;
        w_busy_d  = 1'b1;
        w_fault_d = 1'b0;
        case (w_state_d)
            S_RST, S_SETTLE: begin
                for (int i = 0; i < int'(NUM_CAM); i++) begin
                    if (2'(i) < w_cam_d) begin
                        w_pwdn_d[i]  = 1'b0;
                        w_rst_n_d[i] = 1'b1;
                    end else if (2'(i) == w_cam_d) begin
                        w_pwdn_d[i]  = 1'b0;
                        w_rst_n_d[i] = (w_state_d == S_SETTLE);
                    end
                end
            end
            S_DONE: begin
                w_pwdn_d  = '0;
                w_rst_n_d = '1;
                w_done_d  = 1'b1;
                w_busy_d  = 1'b0;
            end
            S_STBY: begin
                w_rst_n_d = '1;
                w_busy_d  = 1'b0;
            end
            S_WAKE: begin
                w_pwdn_d  = '0;
                w_rst_n_d = '1;
            end
            S_FAULT: begin
                w_busy_d = 1'b0;
`ifdef CAM_PWR_WDOG_EN
                w_fault_d = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_PWDN;
            r_cam   <= 2'd0;
            r_timer <= '0;
            r_pwdn  <= '1;
            r_rst_n <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_fault <= 1'b0;
`ifdef CAM_PWR_WDOG_EN
            r_retry    <= 8'd0;
            r_wdog_arm <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            r_cam   <= w_cam_d;
            r_timer <= w_timer_d;
            r_pwdn  <= w_pwdn_d;
            r_rst_n <= w_rst_n_d;
            r_done  <= w_done_d;
            r_busy  <= w_busy_d;
            r_fault <= w_fault_d;
`ifdef CAM_PWR_WDOG_EN
            r_retry    <= w_retry_d;
            r_wdog_arm <= w_wdog_arm_d;
`endif
        end
    end

    assign cam_pwdn   = r_pwdn;
    assign cam_rst_n  = r_rst_n;
    assign power_done = r_done;
    assign seq_busy   = r_busy;
    assign cur_cam    = r_cam;
    assign pwr_fault  = r_fault;

endmodule
